// File: rtl/data_mem_responder.sv
// Word-addressed data memory responder: one request at a time, LATENCY wait
// states, one-cycle ready pulse. Optional alignment check under DMEM_ALIGN_CHECK_EN.
module data_mem_responder #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        busy
`ifdef DMEM_ALIGN_CHECK_EN
  ,
  output logic        err
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t            r_state, w_state_nxt;
  logic [3:0]        r_cnt, w_cnt_nxt;
  logic [ADDR_W-1:0] r_idx;
  logic [31:0]       r_wdata;
  logic              r_rd, r_wr;
  logic [31:0]       r_mem [2**ADDR_W];

  logic              w_req, w_idle, w_commit, w_fault;
  logic [ADDR_W-1:0] w_idx;
  logic [31:0]       w_wdata;
  logic              w_rd, w_wr;
  logic              w_unused_bits;

  assign w_req  = MemRead | MemWrite;
  assign w_idle = (r_state == S_IDLE);

  // With LATENCY=0 the access happens at the capture edge, so the live
  // inputs stand in for the not-yet-latched request.
  assign w_idx   = w_idle ? addr[ADDR_W+1:2] : r_idx;
  assign w_wdata = w_idle ? write_data       : r_wdata;
  assign w_rd    = w_idle ? MemRead          : r_rd;
  assign w_wr    = w_idle ? MemWrite         : r_wr;

`ifdef DMEM_ALIGN_CHECK_EN
  logic [1:0] r_lsb;
  logic       r_err;
  assign w_fault = w_idle ? (addr[1:0] != 2'b00) : (r_lsb != 2'b00);
  assign err     = r_err;
`else
  assign w_fault = 1'b0;
`endif

  assign w_unused_bits = ^{addr[31:ADDR_W+2], addr[1:0]};

  // The array and read_data act only on the edge that enters RESP.
  assign w_commit = (w_state_nxt == S_RESP) && !reset;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: if (w_req) begin
        w_cnt_nxt   = 4'(LATENCY);
        w_state_nxt = (LATENCY == 0) ? S_RESP : S_BUSY;
      end
      S_BUSY: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt <= 4'd1) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        w_cnt_nxt   = 4'd0;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_cnt_nxt   = 4'd0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_idx     <= '0;
      r_wdata   <= 32'h0;
      r_rd      <= 1'b0;
      r_wr      <= 1'b0;
      read_data <= 32'h0;
`ifdef DMEM_ALIGN_CHECK_EN
      r_lsb     <= 2'b00;
      r_err     <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_idle && w_req) begin
        r_idx   <= addr[ADDR_W+1:2];
        r_wdata <= write_data;
        r_rd    <= MemRead;
        r_wr    <= MemWrite;
`ifdef DMEM_ALIGN_CHECK_EN
        r_lsb   <= addr[1:0];
`endif
      end
      // Reading in the same edge as the write yields the pre-write word.
      if (w_commit && w_rd && !w_fault) read_data <= r_mem[w_idx];
`ifdef DMEM_ALIGN_CHECK_EN
      r_err <= w_commit && w_fault;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (w_commit && w_wr && !w_fault) r_mem[w_idx] <= w_wdata;
  end

  assign ready = (r_state == S_RESP);
  assign busy  = (r_state != S_IDLE);

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: transaction-level memory model,
// directed spec scenarios plus randomized load/store traffic.
module tb_data_mem_responder;
  localparam int AW    = 8;
  localparam int L     = 2;
  localparam int DEPTH = 1 << AW;
`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] write_data = 32'h0;
  logic [31:0] read_data;
  logic        ready;
  logic        busy;
`ifdef DMEM_ALIGN_CHECK_EN
  logic        err;
`endif

  data_mem_responder #(.ADDR_W(AW), .LATENCY(L)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .addr(addr), .write_data(write_data), .read_data(read_data),
    .ready(ready), .busy(busy)
`ifdef DMEM_ALIGN_CHECK_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: word array, validity, and the last load result.
  logic [31:0] m_mem [DEPTH];
  bit          m_vld [DEPTH];
  logic [31:0] m_rd;
  bit          m_rd_ok;

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  // Caller is at a negedge with the DUT idle; returns at a negedge, idle again.
  task automatic do_req(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] wd, input string nm);
    int idx, got;
    bit fault, busy_ok, err_ok;
    logic [31:0] old, rd_at_ready;
    idx   = widx(a);
    fault = ALIGN && (a % 4 != 0);
    old   = m_mem[idx];
    MemRead = rd; MemWrite = wr; addr = a; write_data = wd;
    @(posedge clk); #1;
    MemRead = 1'b0; MemWrite = 1'b0; addr = $urandom; write_data = $urandom;
    got = -1; busy_ok = 1; err_ok = 1; rd_at_ready = 32'h0;
    for (int j = 0; j <= L + 1; j++) begin
      @(negedge clk);
      if (ready === 1'b1) begin
        if (got < 0) begin got = j; rd_at_ready = read_data; end
        else got = 99;
      end
      if (busy !== (j <= L)) busy_ok = 0;
`ifdef DMEM_ALIGN_CHECK_EN
      if (err !== (j == L && fault)) err_ok = 0;
`endif
    end
    checks++;
    if (got !== L) begin
      failures++;
      $display("FAIL %s ready_cycle: got %0d expected %0d", nm, got, L);
    end
    checks++;
    if (busy_ok !== 1'b1) begin
      failures++;
      $display("FAIL %s busy_window: busy not high exactly for cycles 0..%0d", nm, L);
    end
`ifdef DMEM_ALIGN_CHECK_EN
    checks++;
    if (err_ok !== 1'b1) begin
      failures++;
      $display("FAIL %s err_pulse: expected err=%0d only in ready cycle", nm, fault);
    end
`endif
    if (rd && !fault) begin m_rd = old; m_rd_ok = m_vld[idx]; end
    if (m_rd_ok) begin
      checks++;
      if (rd_at_ready !== m_rd) begin
        failures++;
        $display("FAIL %s read_data: got %h expected %h", nm, rd_at_ready, m_rd);
      end
    end
    if (wr && !fault) begin m_mem[idx] = wd; m_vld[idx] = 1'b1; end
  endtask

  task automatic test_reset();
    bit ok;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_rd = 32'h0; m_rd_ok = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      ok = (ready === 1'b0) && (busy === 1'b0) && (read_data === 32'h0);
`ifdef DMEM_ALIGN_CHECK_EN
      ok = ok && (err === 1'b0);
`endif
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL reset_idle cyc%0d: ready=%b busy=%b read_data=%h expected 0/0/0",
                 c, ready, busy, read_data);
      end
    end
  endtask

  task automatic test_fill();
    for (int w = 0; w < 16; w++) do_req(1'b0, 1'b1, 32'(w * 4), $urandom, "fill");
  endtask

  task automatic test_write_read();
    do_req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, "wr_10");
    do_req(1'b1, 1'b0, 32'h10, 32'h0, "rd_10");
    checks++;
    if (read_data !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL rd_10_const: got %h expected deadbeef", read_data);
    end
  endtask

  task automatic test_wrap();
    do_req(1'b0, 1'b1, 32'h400, 32'h12345678, "wr_400");
    do_req(1'b1, 1'b0, 32'h0, 32'h0, "rd_0_wrap");
    checks++;
    if (read_data !== 32'h12345678) begin
      failures++;
      $display("FAIL wrap_const: got %h expected 12345678", read_data);
    end
  endtask

  task automatic test_read_before_write();
    do_req(1'b1, 1'b1, 32'h10, 32'h1, "rbw");
    checks++;
    if (read_data !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL rbw_old: got %h expected deadbeef", read_data);
    end
    do_req(1'b1, 1'b0, 32'h10, 32'h0, "rbw_after");
    checks++;
    if (read_data !== 32'h1) begin
      failures++;
      $display("FAIL rbw_new: got %h expected 00000001", read_data);
    end
  endtask

  task automatic test_reset_mid_write();
    int pulses;
    pulses = 0;
    MemRead = 1'b0; MemWrite = 1'b1; addr = 32'h20; write_data = 32'hAAAA5555;
    @(posedge clk); #1;
    MemWrite = 1'b0; addr = 32'h0; write_data = 32'h0;
    @(negedge clk);            // first BUSY cycle
    @(negedge clk);            // second BUSY cycle
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_rd = 32'h0; m_rd_ok = 1'b1;
    for (int c = 0; c < L + 4; c++) begin
      @(negedge clk);
      if (ready === 1'b1 || busy === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      failures++;
      $display("FAIL reset_mid_ready: saw %0d active cycles expected 0", pulses);
    end
    checks++;
    if (read_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_mid_rdata: got %h expected 0", read_data);
    end
    do_req(1'b1, 1'b0, 32'h20, 32'h0, "reset_mid_old");
  endtask

  task automatic test_align();
    do_req(1'b0, 1'b1, 32'h22, 32'h5A5AA5A5, "align_wr");
    do_req(1'b1, 1'b0, 32'h20, 32'h0, "align_rd");
  endtask

  task automatic test_back_to_back();
    int pos [3];
    int n;
    logic [31:0] exp;
    n = 0;
    exp = m_mem[widx(32'h10)];
    MemRead = 1'b1; MemWrite = 1'b0; addr = 32'h10;
    for (int k = 0; k <= 3 * L + 5; k++) begin
      @(negedge clk);
      if (ready === 1'b1) begin
        if (n < 3) pos[n] = k;
        n++;
      end
    end
    MemRead = 1'b0;
    checks++;
    if (n !== 3) begin
      failures++;
      $display("FAIL b2b_count: got %0d pulses expected 3", n);
    end else begin
      checks++;
      if (pos[0] !== L || pos[1] - pos[0] !== L + 2 || pos[2] - pos[1] !== L + 2) begin
        failures++;
        $display("FAIL b2b_spacing: pulses at %0d,%0d,%0d expected %0d,%0d,%0d",
                 pos[0], pos[1], pos[2], L, 2 * L + 2, 3 * L + 4);
      end
    end
    checks++;
    if (read_data !== exp) begin
      failures++;
      $display("FAIL b2b_rdata: got %h expected %h", read_data, exp);
    end
    m_rd = exp; m_rd_ok = 1'b1;
  endtask

  task automatic test_random();
    bit rd, wr;
    logic [31:0] a;
    for (int i = 0; i < 60; i++) begin
      rd = bit'($urandom_range(0, 1));
      wr = rd ? ($urandom_range(0, 3) == 0) : 1'b1;
      a  = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 15)) << 2);
      if ($urandom_range(0, 4) == 0) a = a | 32'($urandom_range(1, 3));
      do_req(rd, wr, a, $urandom, "random");
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_write_read();
    test_wrap();
    test_read_before_write();
    test_back_to_back();
    test_reset_mid_write();
    test_align();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
